// File: rtl/sdram_frame_writer_pkg.sv
// sdram_frame_writer_pkg: FSM states and round-robin grant selection
package sdram_frame_writer_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [3:0] rr_pick(input logic [7:0] elig, input logic [2:0] last, input int n);
    logic [2:0] idx;
    rr_pick = 4'h8;
    for (int k = 8; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % n);
      if (k <= n && elig[idx]) rr_pick = {1'b0, idx};
    end
  endfunction
endpackage

// File: rtl/sdram_wr_fifo.sv
// sdram_wr_fifo: show-ahead synchronous FIFO with occupancy count
module sdram_wr_fifo #(
  parameter int DW = 64,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic accept;
  assign full = count == (AW+1)'(DEPTH);
  assign accept = push && (!full || pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (accept) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
    end
endmodule

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: drains CH_NUM pixel streams into ping-pong SDRAM frame buffers
module sdram_frame_writer
  import sdram_frame_writer_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 29,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int FRAME_WORDS = 259200,
  parameter int BASE_ADDR = 0,
  localparam int BW = $clog2(BURST_LEN) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH_NUM-1:0]        ch_valid,
  input  logic [CH_NUM-1:0]        ch_sof,
  input  logic [CH_NUM*DATA_W-1:0] ch_data,
  input  logic                     err_clr,
  output logic [ADDR_W-1:0]        avm_address,
  output logic [BW-1:0]            avm_burstcount,
  output logic                     avm_write,
  output logic [DATA_W-1:0]        avm_writedata,
  output logic [DATA_W/8-1:0]      avm_byteenable,
  input  logic                     avm_waitrequest,
  output logic [CH_NUM-1:0]        frame_done,
  output logic [CH_NUM-1:0]        rd_buf,
  output logic [CH_NUM-1:0]        ovf,
  output logic [CH_NUM-1:0]        sof_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  logic [DATA_W-1:0] head [CH_NUM];
  logic [CW-1:0] cnt [CH_NUM];
  logic [ADDR_W-1:0] offset [CH_NUM];
  logic [ADDR_W-1:0] wcnt [CH_NUM];
  logic [CH_NUM-1:0] full, pop, wbuf;
  logic [7:0] elig;
  logic [3:0] pick;
  logic [GW-1:0] pg, grant, last_grant;
  logic [BW-1:0] beat;
  logic accept;
  state_t state;
  assign accept = avm_write && !avm_waitrequest;
  assign avm_byteenable = '1;
  assign avm_writedata = avm_write ? head[grant] : '0;
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign pop[g] = accept && grant == GW'(g);
    sdram_wr_fifo #(.DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(reset), .push(ch_valid[g]), .pop(pop[g]),
      .din(ch_data[g*DATA_W +: DATA_W]), .dout(head[g]), .count(cnt[g]), .full(full[g])
    );
  end
  always_comb begin
    elig = '0;
    for (int i = 0; i < CH_NUM; i++) elig[i] = cnt[i] >= CW'(BURST_LEN);
    pick = rr_pick(elig, 3'(last_grant), CH_NUM);
    pg = GW'(pick[2:0]);
  end
  // input word counters only police frame alignment; they never resync
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ovf <= '0;
      sof_err <= '0;
      for (int i = 0; i < CH_NUM; i++) wcnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (err_clr) ovf[i] <= 1'b0;
        else if (ch_valid[i] && full[i] && !pop[i]) ovf[i] <= 1'b1;
        if (err_clr) sof_err[i] <= 1'b0;
        else if (ch_valid[i] && ch_sof[i] && wcnt[i] != '0) sof_err[i] <= 1'b1;
        if (ch_valid[i]) wcnt[i] <= wcnt[i] == ADDR_W'(FRAME_WORDS-1) ? '0 : wcnt[i] + 1'b1;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(CH_NUM-1);
      beat <= '0;
      avm_write <= 1'b0;
      avm_address <= '0;
      avm_burstcount <= '0;
      frame_done <= '0;
      rd_buf <= '1;
      wbuf <= '0;
      for (int i = 0; i < CH_NUM; i++) offset[i] <= '0;
    end else begin
      frame_done <= '0;
      if (state == IDLE) begin
        if (!pick[3]) begin
          grant <= pg;
          last_grant <= pg;
          beat <= '0;
          avm_write <= 1'b1;
          avm_burstcount <= BW'(BURST_LEN);
          avm_address <= ADDR_W'(BASE_ADDR) + ADDR_W'((int'(pg)*2 + int'(wbuf[pg])) * FRAME_WORDS) + offset[pg];
          state <= BURST;
        end
      end else if (accept) begin
        beat <= beat + 1'b1;
        if (beat == BW'(BURST_LEN-1)) begin
          avm_write <= 1'b0;
          state <= IDLE;
          if (offset[grant] == ADDR_W'(FRAME_WORDS-BURST_LEN)) begin
            offset[grant] <= '0;
            rd_buf[grant] <= wbuf[grant];
            wbuf[grant] <= ~wbuf[grant];
            frame_done[grant] <= 1'b1;
          end else offset[grant] <= offset[grant] + ADDR_W'(BURST_LEN);
        end
      end
    end
endmodule

// File: tb/tb_sdram_frame_writer.sv
// tb_sdram_frame_writer: table vectors, corner sequences and random traffic against a queue model
module tb_sdram_frame_writer;
  localparam int CH = 2, DW = 64, AW = 29, BL = 4, FW = 8, FD = 8, BASE = 32'h1000;
  logic clk = 0, reset = 1, err_clr = 0, avm_waitrequest = 0;
  logic [CH-1:0] ch_valid = '0, ch_sof = '0;
  logic [CH*DW-1:0] ch_data = '0;
  logic [AW-1:0] avm_address;
  logic [2:0] avm_burstcount;
  logic avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic [CH-1:0] frame_done, rd_buf, ovf, sof_err;

  sdram_frame_writer #(.CH_NUM(CH), .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD),
    .FRAME_WORDS(FW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_sof(ch_sof), .ch_data(ch_data),
    .err_clr(err_clr), .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .frame_done(frame_done), .rd_buf(rd_buf),
    .ovf(ovf), .sof_err(sof_err));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] mask; int n; int sof_pos; logic [1:0] exp_sof; logic [1:0] exp_rd;} vec_t;
  vec_t vt[5];
  int total = 0, bad = 0, cyc = 0, nb = 0, seq = 0;
  bit prev_w = 0;
  logic [63:0] q [CH][$];
  int done [CH];
  bit pend [CH];
  int starts[$], start_ch[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // model: per-channel word queues, beats_done gives buffer/offset by plain arithmetic
  task automatic monitor();
    int c, b;
    logic [63:0] w;
    cyc++;
    for (int i = 0; i < CH; i++) begin
      chk("frame_done", 64'(frame_done[i]), 64'(pend[i]));
      if (pend[i]) chk("rd_buf_at_done", 64'(rd_buf[i]), 64'(((done[i] / FW) - 1) % 2));
      pend[i] = 0;
    end
    if (avm_write && !prev_w) begin
      starts.push_back(cyc);
      start_ch.push_back(int'(avm_writedata[63:56]));
      nb = 0;
    end
    if (!avm_write && prev_w) chk("burst_beats", 64'(nb), 64'(BL));
    if (avm_write && !avm_waitrequest) begin
      c = int'(avm_writedata[63:56]);
      if (c >= CH || q[c].size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_beat: got data %0h with no word queued", avm_writedata);
      end else begin
        w = q[c].pop_front();
        chk("beat_data", avm_writedata, w);
        b = done[c] - done[c] % BL;
        chk("beat_addr", 64'(avm_address), 64'(BASE + (c*2 + (b / FW) % 2) * FW + b % FW));
        chk("burstcount", 64'(avm_burstcount), 64'(BL));
        done[c]++;
        nb++;
        if (done[c] % FW == 0) pend[c] = 1;
      end
    end
    prev_w = avm_write;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] mask, input logic [1:0] sof, input bit keep);
    logic [63:0] w;
    for (int c = 0; c < CH; c++) if (mask[c]) begin
      w = {8'(c), 24'($urandom), 32'(seq)};
      seq++;
      ch_data[c*DW +: DW] = w;
      if (keep) q[c].push_back(w);
    end
    ch_valid = mask;
    ch_sof = sof;
    tick();
    ch_valid = '0;
    ch_sof = '0;
  endtask

  task automatic drain();
    int k = 0;
    while (k < 300 && (q[0].size() >= BL || q[1].size() >= BL || avm_write)) begin
      tick();
      k++;
    end
    chk("drain_timeout", 64'(k < 300), 64'(1));
  endtask

  initial begin
    logic [63:0] d;
    logic [AW-1:0] a;
    int k;
    logic [1:0] m;
    vt[0] = '{2'b01, 16, -1, 2'b00, 2'b11};
    vt[1] = '{2'b10, 12, -1, 2'b00, 2'b11};
    vt[2] = '{2'b11, 8, -1, 2'b00, 2'b00};
    vt[3] = '{2'b01, 4, 3, 2'b01, 2'b01};
    vt[4] = '{2'b10, 4, 0, 2'b01, 2'b01};
    for (int i = 0; i < CH; i++) begin done[i] = 0; pend[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", 64'(avm_write), 0);
    chk("rst_addr", 64'(avm_address), 0);
    chk("rst_bc", 64'(avm_burstcount), 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_fd", 64'(frame_done), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_sof", 64'(sof_err), 0);
    chk("rst_rdbuf", 64'(rd_buf), 64'(2'b11));
    chk("byteenable", 64'(avm_byteenable), 64'(8'hff));
    reset = 0;
    tick();
    // simultaneous arrival: ch0 wins, ch1 follows after one idle cycle
    repeat (4) push(2'b11, 2'b00, 1);
    k = 0;
    while (starts.size() < 2 && k < 50) begin tick(); k++; end
    chk("dual_starts", 64'(starts.size()), 2);
    if (starts.size() >= 2) begin
      chk("dual_first_ch", 64'(start_ch[0]), 0);
      chk("dual_second_ch", 64'(start_ch[1]), 1);
      chk("dual_gap", 64'(starts[1] - starts[0]), 5);
    end
    drain();
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        push(vt[v].mask, i == vt[v].sof_pos ? vt[v].mask : 2'b00, 1);
        tick();
      end
      drain();
      chk("vec_sof_err", 64'(sof_err), 64'(vt[v].exp_sof));
      chk("vec_rd_buf", 64'(rd_buf), 64'(vt[v].exp_rd));
      chk("vec_ovf", 64'(ovf), 0);
    end
    // waitrequest stall on the second beat
    repeat (4) push(2'b01, 2'b00, 1);
    k = 0;
    while (!avm_write && k < 20) begin tick(); k++; end
    tick();
    avm_waitrequest = 1;
    a = avm_address;
    d = avm_writedata;
    chk("stall_addr0", 64'(a), 64'(BASE));
    if (q[0].size() > 0) chk("stall_head", d, q[0][0]);
    repeat (5) begin
      tick();
      chk("stall_addr", 64'(avm_address), 64'(a));
      chk("stall_bc", 64'(avm_burstcount), 64'(BL));
      chk("stall_data", avm_writedata, d);
    end
    avm_waitrequest = 0;
    drain();
    // overflow while the slave stalls, then clear
    avm_waitrequest = 1;
    for (int i = 0; i < 9; i++) push(2'b10, 2'b00, i < 8);
    chk("ovf_set", 64'(ovf), 64'(2'b10));
    tick();
    chk("ovf_sticky", 64'(ovf), 64'(2'b10));
    chk("sof_sticky", 64'(sof_err), 64'(2'b01));
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("ovf_clr", 64'(ovf), 0);
    chk("sof_clr", 64'(sof_err), 0);
    avm_waitrequest = 0;
    drain();
    // random traffic; pacing keeps every FIFO below capacity
    repeat (400) begin
      avm_waitrequest = ($urandom % 10) < 3;
      m = '0;
      for (int c = 0; c < CH; c++) m[c] = ($urandom % 3 == 0) && q[c].size() < 6;
      push(m, 2'b00, 1);
    end
    avm_waitrequest = 0;
    drain();
    chk("rand_ovf", 64'(ovf), 0);
    // asynchronous reset in the middle of a burst
    repeat (4) push(2'b01, 2'b00, 1);
    k = 0;
    while (!avm_write && k < 20) begin tick(); k++; end
    tick();
    chk("mid_write_before", 64'(avm_write), 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_write", 64'(avm_write), 0);
    chk("mid_rst_addr", 64'(avm_address), 0);
    chk("mid_rst_bc", 64'(avm_burstcount), 0);
    chk("mid_rst_wdata", avm_writedata, 0);
    chk("mid_rst_rdbuf", 64'(rd_buf), 64'(2'b11));
    for (int c = 0; c < CH; c++) begin q[c].delete(); done[c] = 0; pend[c] = 0; end
    prev_w = 0;
    nb = 0;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (10) tick();
    chk("flushed_idle", 64'(avm_write), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
